// File: rtl/rd_channel_return_router.sv
`default_nettype none
// ============================================================================
//  Module   : rd_channel_return_router
//  Purpose  : Read-data (R) return path of the interconnect. Routes R beats
//             from the single slave port M00 back to whichever master (S00 or
//             S01) won the matching AR arbitration. Every AR grant pushes the
//             granted master ID into an in-order queue. The last R beat of a
//             burst (rlast handshake) pops the queue.
//  Ports    :
//    ACLK, ARESETN          clock (rising edge), async active-low reset
//    AR_Selected_Master     master ID granted on AR this cycle
//    AR_Access_Grant        AR handshake done at slave; enqueue the ID
//    Queue_Is_Full          queue holds Queue_Depth entries
//    Read_Data_Master       ID at queue head (0 when empty)
//    Read_Data_Finish       1-cycle pulse in the cycle after an rlast pop
//    Unexpected_Rdata       sticky flag: slave rvalid seen with empty queue
//    M00_AXI_r*             R channel from the slave, rready back to it
//    S00_AXI_r*, S01_AXI_r* R channel to master 0 / 1, rready from them
//  Revision : 1.0  initial release
// ============================================================================
module rd_channel_return_router #(
    parameter int Masters_Num             = 2,
    parameter int Masters_ID_Size         = $clog2(Masters_Num),
    parameter int Queue_Depth             = 4,
    parameter int M00_Read_data_bus_width = 32
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,

    // AR-side bookkeeping
    input  logic [Masters_ID_Size-1:0]         AR_Selected_Master,
    input  logic                               AR_Access_Grant,
    output logic                               Queue_Is_Full,
    output logic [Masters_ID_Size-1:0]         Read_Data_Master,
    output logic                               Read_Data_Finish,
    output logic                               Unexpected_Rdata,

    // R channel from the slave
    input  logic [M00_Read_data_bus_width-1:0] M00_AXI_rdata,
    input  logic [1:0]                         M00_AXI_rresp,
    input  logic                               M00_AXI_rlast,
    input  logic                               M00_AXI_rvalid,
    output logic                               M00_AXI_rready,

    // R channel to master 0
    output logic [M00_Read_data_bus_width-1:0] S00_AXI_rdata,
    output logic [1:0]                         S00_AXI_rresp,
    output logic                               S00_AXI_rlast,
    output logic                               S00_AXI_rvalid,
    input  logic                               S00_AXI_rready,

    // R channel to master 1
    output logic [M00_Read_data_bus_width-1:0] S01_AXI_rdata,
    output logic [1:0]                         S01_AXI_rresp,
    output logic                               S01_AXI_rlast,
    output logic                               S01_AXI_rvalid,
    input  logic                               S01_AXI_rready
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int PTR_W = $clog2(Queue_Depth);
    // The count must represent 0..Queue_Depth inclusive, so it needs one more bit than a pointer.
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(Queue_Depth);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_PTR1  = PTR_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,   // queue empty, the slave is stalled
        ST_ROUTE = 1'b1    // queue non-empty, R beats are forwarded to the head master
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic                       finish_q, finish_d;
    logic                       unexp_q, unexp_d;
    logic [Masters_ID_Size-1:0] mem_q [Queue_Depth];

    // ------------------------------------------------------------------------
    // Routing and queue control (combinational)
    // ------------------------------------------------------------------------
    logic [Masters_ID_Size-1:0] head;
    logic                       route;
    logic                       sel0;
    logic                       sel1;
    logic                       m00_rready;
    logic                       push;
    logic                       pop;

    assign head  = mem_q[rd_ptr_q];
    assign route = (state_q == ST_ROUTE);
    assign sel0  = route && (head == Masters_ID_Size'(0));
    assign sel1  = route && (head == Masters_ID_Size'(1));

    // The slave sees only the ready of the head master. In IDLE it sees 0, so
    // a stray beat is held at the slave instead of being lost.
    assign m00_rready = (sel0 && S00_AXI_rready) || (sel1 && S01_AXI_rready);

    // Only the last beat of a burst retires the queue entry. The number of
    // beats before that is not limited.
    assign pop  = M00_AXI_rvalid && m00_rready && M00_AXI_rlast;
    // A pop in the same cycle frees a slot, so a grant is accepted even when the queue is full.
    assign push = AR_Access_Grant && ((cnt_q != C_DEPTH) || pop);

    assign M00_AXI_rready   = m00_rready;
    assign Queue_Is_Full    = (cnt_q == C_DEPTH);
    assign Read_Data_Master = route ? head : '0;
    assign Read_Data_Finish = finish_q;
    assign Unexpected_Rdata = unexp_q;

    // Master 0 port: slave values when selected, otherwise all zero.
    assign S00_AXI_rvalid = sel0 && M00_AXI_rvalid;
    assign S00_AXI_rdata  = sel0 ? M00_AXI_rdata : '0;
    assign S00_AXI_rresp  = sel0 ? M00_AXI_rresp : 2'b00;
    assign S00_AXI_rlast  = sel0 && M00_AXI_rlast;

    // Master 1 port: slave values when selected, otherwise all zero.
    assign S01_AXI_rvalid = sel1 && M00_AXI_rvalid;
    assign S01_AXI_rdata  = sel1 ? M00_AXI_rdata : '0;
    assign S01_AXI_rresp  = sel1 ? M00_AXI_rresp : 2'b00;
    assign S01_AXI_rlast  = sel1 && M00_AXI_rlast;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        finish_d = pop;
        unexp_d  = unexp_q;

        // Queue_Depth is a power of two, so the pointers wrap on natural overflow.
        if (push) begin
            wr_ptr_d = wr_ptr_q + C_PTR1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR1;
        end

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + C_ONE;
            2'b01:   cnt_d = cnt_q - C_ONE;
            default: cnt_d = cnt_q;
        endcase

        unique case (state_q)
            ST_IDLE: begin
                if (M00_AXI_rvalid) begin
                    unexp_d = 1'b1;
                end
                if (push) begin
                    state_d = ST_ROUTE;
                end
            end
            ST_ROUTE: begin
                // A push in the same cycle keeps the queue non-empty.
                if (pop && !push && (cnt_q == C_ONE)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            finish_q <= 1'b0;
            unexp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            finish_q <= finish_d;
            unexp_q  <= unexp_d;
        end
    end

    // Queue storage is not reset. An entry is read only while the FSM is in ROUTE,
    // and in that state the entry has already been written.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= AR_Selected_Master;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rd_channel_return_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rd_channel_return_router
//  Purpose  : Self-checking bench for rd_channel_return_router. A vector table
//             covers single-beat, multi-beat and multi-outstanding routing.
//             Hand-written sequences cover the full queue, stray data and
//             reset during a burst. A queue of granted master IDs is compared
//             against the port that receives each final beat.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rd_channel_return_router;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        grant;
    logic        full;
    logic        rdm;
    logic        fin;
    logic        unexp;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] s0_rdata;
    logic [1:0]  s0_rresp;
    logic        s0_rlast;
    logic        s0_rvalid;
    logic        s0_rready;
    logic [31:0] s1_rdata;
    logic [1:0]  s1_rresp;
    logic        s1_rlast;
    logic        s1_rvalid;
    logic        s1_rready;

    int errors = 0;
    int checks = 0;
    logic sb_q[$];      // master IDs expected to receive a final beat, oldest first

    rd_channel_return_router dut (
        .ACLK               (clk),
        .ARESETN            (rst_n),
        .AR_Selected_Master (sel),
        .AR_Access_Grant    (grant),
        .Queue_Is_Full      (full),
        .Read_Data_Master   (rdm),
        .Read_Data_Finish   (fin),
        .Unexpected_Rdata   (unexp),
        .M00_AXI_rdata      (m_rdata),
        .M00_AXI_rresp      (m_rresp),
        .M00_AXI_rlast      (m_rlast),
        .M00_AXI_rvalid     (m_rvalid),
        .M00_AXI_rready     (m_rready),
        .S00_AXI_rdata      (s0_rdata),
        .S00_AXI_rresp      (s0_rresp),
        .S00_AXI_rlast      (s0_rlast),
        .S00_AXI_rvalid     (s0_rvalid),
        .S00_AXI_rready     (s0_rready),
        .S01_AXI_rdata      (s1_rdata),
        .S01_AXI_rresp      (s1_rresp),
        .S01_AXI_rlast      (s1_rlast),
        .S01_AXI_rvalid     (s1_rvalid),
        .S01_AXI_rready     (s1_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        g;
        logic        sel;
        logic        rv;
        logic [31:0] rd;
        logic        rl;
        logic        r0;
        logic        r1;
        logic        e_v0;
        logic        e_v1;
        logic        e_rr;
        logic        e_rdm;
        logic        e_fin;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(logic g, logic s, logic rv, logic [31:0] rd, logic rl,
                                logic r0, logic r1, logic ev0, logic ev1, logic err,
                                logic erdm, logic efin, logic [31:0] ed0, logic [31:0] ed1);
        vec_t v;
        v.g = g;     v.sel = s;    v.rv = rv;     v.rd = rd;       v.rl = rl;
        v.r0 = r0;   v.r1 = r1;    v.e_v0 = ev0;  v.e_v1 = ev1;    v.e_rr = err;
        v.e_rdm = erdm; v.e_fin = efin; v.e_d0 = ed0; v.e_d1 = ed1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare any final-beat handshake seen at a master port with the queue of granted IDs.
    task automatic observe();
        logic exp_id;
        if (s0_rvalid && s0_rready && s0_rlast) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_last_s00", 32'd1, 32'd0);
            end else begin
                exp_id = sb_q.pop_front();
                chk("sb_route_s00", 32'd0, {31'd0, exp_id});
            end
        end
        if (s1_rvalid && s1_rready && s1_rlast) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_last_s01", 32'd1, 32'd0);
            end else begin
                exp_id = sb_q.pop_front();
                chk("sb_route_s01", 32'd1, {31'd0, exp_id});
            end
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, then let the
    // combinational outputs settle before they are sampled.
    task automatic cyc(input logic g, input logic s, input logic acc, input logic rv,
                       input logic [31:0] rd, input logic rl, input logic r0, input logic r1);
        @(negedge clk);
        grant = g; sel = s; m_rvalid = rv; m_rdata = rd; m_rlast = rl;
        s0_rready = r0; s1_rready = r1;
        #1;
        observe();
        if (acc) sb_q.push_back(s);
    endtask

    logic [3:0] drain_order;

    initial begin
        rst_n = 1'b0; grant = 1'b0; sel = 1'b0; m_rdata = '0; m_rresp = 2'b00;
        m_rlast = 1'b0; m_rvalid = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s0_rvalid", {31'd0, s0_rvalid}, 32'd0);
        chk("rst_s1_rvalid", {31'd0, s1_rvalid}, 32'd0);
        chk("rst_m_rready",  {31'd0, m_rready},  32'd0);
        chk("rst_rdm",       {31'd0, rdm},       32'd0);
        chk("rst_full",      {31'd0, full},      32'd0);
        chk("rst_fin",       {31'd0, fin},       32'd0);
        chk("rst_unexp",     {31'd0, unexp},     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table: single beat, 4-beat burst, three outstanding ----------------
        //            g s rv rd            rl r0 r1  v0 v1 rr rdm fin d0            d1
        tbl[0]  = mk(1,0,0, 32'h0,        0, 0, 0,  0, 0, 0, 0,  0, 32'h0,        32'h0);
        tbl[1]  = mk(0,0,1, 32'hDEADBEEF, 1, 1, 0,  1, 0, 1, 0,  0, 32'hDEADBEEF, 32'h0);
        tbl[2]  = mk(0,0,0, 32'h0,        0, 0, 0,  0, 0, 0, 0,  1, 32'h0,        32'h0);
        tbl[3]  = mk(0,0,0, 32'h0,        0, 0, 0,  0, 0, 0, 0,  0, 32'h0,        32'h0);
        tbl[4]  = mk(1,1,0, 32'h0,        0, 0, 0,  0, 0, 0, 0,  0, 32'h0,        32'h0);
        tbl[5]  = mk(0,0,1, 32'h1000,     0, 0, 0,  0, 1, 0, 1,  0, 32'h0,        32'h1000);
        tbl[6]  = mk(0,0,1, 32'h1000,     0, 0, 1,  0, 1, 1, 1,  0, 32'h0,        32'h1000);
        tbl[7]  = mk(0,0,1, 32'h1001,     0, 0, 0,  0, 1, 0, 1,  0, 32'h0,        32'h1001);
        tbl[8]  = mk(0,0,1, 32'h1001,     0, 0, 1,  0, 1, 1, 1,  0, 32'h0,        32'h1001);
        tbl[9]  = mk(0,0,1, 32'h1002,     0, 0, 1,  0, 1, 1, 1,  0, 32'h0,        32'h1002);
        tbl[10] = mk(0,0,1, 32'h1003,     1, 0, 0,  0, 1, 0, 1,  0, 32'h0,        32'h1003);
        tbl[11] = mk(0,0,1, 32'h1003,     1, 0, 1,  0, 1, 1, 1,  0, 32'h0,        32'h1003);
        tbl[12] = mk(0,0,0, 32'h0,        0, 0, 0,  0, 0, 0, 0,  1, 32'h0,        32'h0);
        tbl[13] = mk(1,0,0, 32'h0,        0, 1, 1,  0, 0, 0, 0,  0, 32'h0,        32'h0);
        tbl[14] = mk(1,1,0, 32'h0,        0, 1, 1,  0, 0, 1, 0,  0, 32'h0,        32'h0);
        tbl[15] = mk(1,0,0, 32'h0,        0, 1, 1,  0, 0, 1, 0,  0, 32'h0,        32'h0);
        tbl[16] = mk(0,0,1, 32'hA0,       0, 1, 1,  1, 0, 1, 0,  0, 32'hA0,       32'h0);
        tbl[17] = mk(0,0,1, 32'hA1,       1, 1, 1,  1, 0, 1, 0,  0, 32'hA1,       32'h0);
        tbl[18] = mk(0,0,1, 32'hB0,       0, 1, 1,  0, 1, 1, 1,  1, 32'h0,        32'hB0);
        tbl[19] = mk(0,0,1, 32'hB1,       1, 1, 1,  0, 1, 1, 1,  0, 32'h0,        32'hB1);
        tbl[20] = mk(0,0,1, 32'hC0,       0, 1, 1,  1, 0, 1, 0,  1, 32'hC0,       32'h0);
        tbl[21] = mk(0,0,1, 32'hC1,       1, 1, 1,  1, 0, 1, 0,  0, 32'hC1,       32'h0);
        tbl[22] = mk(0,0,0, 32'h0,        0, 1, 1,  0, 0, 0, 0,  1, 32'h0,        32'h0);
        tbl[23] = mk(0,0,0, 32'h0,        0, 0, 0,  0, 0, 0, 0,  0, 32'h0,        32'h0);

        for (int i = 0; i < 24; i++) begin
            cyc(tbl[i].g, tbl[i].sel, tbl[i].g, tbl[i].rv, tbl[i].rd, tbl[i].rl,
                tbl[i].r0, tbl[i].r1);
            chk($sformatf("v%0d_s0_rvalid", i), {31'd0, s0_rvalid}, {31'd0, tbl[i].e_v0});
            chk($sformatf("v%0d_s1_rvalid", i), {31'd0, s1_rvalid}, {31'd0, tbl[i].e_v1});
            chk($sformatf("v%0d_m_rready", i),  {31'd0, m_rready},  {31'd0, tbl[i].e_rr});
            chk($sformatf("v%0d_rdm", i),       {31'd0, rdm},       {31'd0, tbl[i].e_rdm});
            chk($sformatf("v%0d_fin", i),       {31'd0, fin},       {31'd0, tbl[i].e_fin});
            chk($sformatf("v%0d_s0_rdata", i),  s0_rdata,           tbl[i].e_d0);
            chk($sformatf("v%0d_s1_rdata", i),  s1_rdata,           tbl[i].e_d1);
            chk($sformatf("v%0d_full", i),      {31'd0, full},      32'd0);
        end
        chk("tbl_unexp", {31'd0, unexp}, 32'd0);

        // ---------------- full queue, push with pop, dropped grant ----------------
        cyc(1, 0, 1, 0, 32'h0, 0, 0, 0);
        cyc(1, 1, 1, 0, 32'h0, 0, 0, 0);
        cyc(1, 0, 1, 0, 32'h0, 0, 0, 0);
        chk("fill3_not_full", {31'd0, full}, 32'd0);
        cyc(1, 1, 1, 0, 32'h0, 0, 0, 0);
        cyc(0, 0, 0, 0, 32'h0, 0, 0, 0);
        chk("fill4_full", {31'd0, full}, 32'd1);
        // The grant arrives with the final beat, so it is accepted and the queue stays full.
        cyc(1, 0, 1, 1, 32'hD0, 1, 1, 1);
        chk("pushpop_full_before", {31'd0, full}, 32'd1);
        chk("pushpop_s0_rvalid",   {31'd0, s0_rvalid}, 32'd1);
        chk("pushpop_m_rready",    {31'd0, m_rready}, 32'd1);
        // No pop in this cycle, so the grant is dropped.
        cyc(1, 1, 0, 0, 32'h0, 0, 0, 0);
        chk("pushpop_full_after", {31'd0, full}, 32'd1);
        chk("pushpop_new_head",   {31'd0, rdm},  32'd1);
        chk("pushpop_fin",        {31'd0, fin},  32'd1);
        cyc(0, 0, 0, 0, 32'h0, 0, 0, 0);
        chk("drop_still_full", {31'd0, full}, 32'd1);
        drain_order = 4'b0101;   // bit k = expected head for drain beat k: 1,0,1,0
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 1, 32'hE0 + k, 1, 1, 1);
            chk($sformatf("drain%0d_head", k), {31'd0, rdm}, {31'd0, drain_order[k]});
        end
        cyc(0, 0, 0, 0, 32'h0, 1, 1, 1);
        chk("drain_empty_full", {31'd0, full},     32'd0);
        chk("drain_empty_rdm",  {31'd0, rdm},      32'd0);
        chk("drain_empty_rr",   {31'd0, m_rready}, 32'd0);
        chk("drain_fin",        {31'd0, fin},      32'd1);

        // ---------------- stray data with empty queue ----------------
        chk("pre_unexp", {31'd0, unexp}, 32'd0);
        cyc(0, 0, 0, 1, 32'h55, 1, 1, 1);
        chk("stray_rr", {31'd0, m_rready},  32'd0);
        chk("stray_v0", {31'd0, s0_rvalid}, 32'd0);
        chk("stray_v1", {31'd0, s1_rvalid}, 32'd0);
        cyc(0, 0, 0, 0, 32'h0, 0, 0, 0);
        chk("stray_unexp_set", {31'd0, unexp}, 32'd1);
        cyc(0, 0, 0, 0, 32'h0, 0, 0, 0);
        chk("stray_unexp_sticky", {31'd0, unexp}, 32'd1);

        // ---------------- reset in the middle of a burst ----------------
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst2_unexp_clr", {31'd0, unexp}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 1, 1, 0, 32'h0, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'hF0, 0, 0, 1);
        chk("mid_beat1_v1", {31'd0, s1_rvalid}, 32'd1);
        cyc(0, 0, 0, 1, 32'hF1, 0, 0, 1);
        chk("mid_beat2_v1", {31'd0, s1_rvalid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_v1",    {31'd0, s1_rvalid}, 32'd0);
        chk("mid_rst_rr",    {31'd0, m_rready},  32'd0);
        chk("mid_rst_full",  {31'd0, full},      32'd0);
        chk("mid_rst_rdm",   {31'd0, rdm},       32'd0);
        chk("mid_rst_fin",   {31'd0, fin},       32'd0);
        chk("mid_rst_unexp", {31'd0, unexp},     32'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 1, 32'hF2, 0, 0, 1);
        chk("post_rst_v1", {31'd0, s1_rvalid}, 32'd0);
        chk("post_rst_rr", {31'd0, m_rready},  32'd0);
        cyc(0, 0, 0, 0, 32'h0, 0, 0, 0);
        chk("post_rst_unexp", {31'd0, unexp}, 32'd1);

        chk("sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
